game_input_ctrl: RTL and testbench

Player-input front end for the minesweeper build. It synchronises and debounces the five raw board buttons and moves a cursor over the game grid, with wrap-around at the edges. It presents the processor with the `pressed`, `x_game` and `y_game` values that the game-check instructions read into the ALU. It sits directly upstream of the processor and consumes the processor's `pr_reset` pulse, which the clear-press instruction raises, to re-arm after each move.

---
 rtl/game_input_ctrl.sv | 122 ++++++++++++
 tb/tb_game_input_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_input_ctrl.sv
// Player-input front end: synchronises and debounces five buttons, moves a
// wrap-around cursor over the grid and latches select presses until cleared.
module game_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int GRID_COLS       = 16,
  parameter int GRID_ROWS       = 12,
  parameter int CELL            = 32,
  parameter int X0              = 64,
  parameter int Y0              = 48
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_sel,
  input  logic       pr_reset,
  output logic       pressed,
  output logic [9:0] x_game,
  output logic [8:0] y_game,
  output logic [4:0] cursor_col,
  output logic [4:0] cursor_row
);

  localparam int NB = 5;
  localparam int B_UP = 0;
  localparam int B_DOWN = 1;
  localparam int B_LEFT = 2;
  localparam int B_RIGHT = 3;
  localparam int B_SEL = 4;
  localparam logic [19:0] CNT_MAX = 20'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]  COL_MAX = 5'(GRID_COLS - 1);
  localparam logic [4:0]  ROW_MAX = 5'(GRID_ROWS - 1);

  logic [NB-1:0]       raw_s;
  logic [NB-1:0]       s1_q, s2_q, deb_q, deb_d, rise_s;
  logic [NB-1:0][19:0] cnt_q, cnt_d;
  logic [4:0]          col_q, col_d, row_q, row_d;
  logic                pressed_q, pressed_d;

  assign raw_s = {btn_sel, btn_right, btn_left, btn_down, btn_up};

  // Debounce: a level flips only after DEBOUNCE_CYCLES consecutive mismatches.
  always_comb begin
    deb_d  = deb_q;
    cnt_d  = '0;
    rise_s = '0;
    for (int i = 0; i < NB; i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = 20'd0;
      end else if (cnt_q[i] == CNT_MAX) begin
        deb_d[i]  = s2_q[i];
        cnt_d[i]  = 20'd0;
        rise_s[i] = s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 20'd1;
      end
    end
  end

  // Cursor and press latch; opposite rises on one axis cancel.
  always_comb begin
    col_d     = col_q;
    row_d     = row_q;
    pressed_d = pressed_q;
    if (!pressed_q) begin
      if (rise_s[B_RIGHT] && !rise_s[B_LEFT]) begin
        col_d = (col_q == COL_MAX) ? 5'd0 : col_q + 5'd1;
      end else if (rise_s[B_LEFT] && !rise_s[B_RIGHT]) begin
        col_d = (col_q == 5'd0) ? COL_MAX : col_q - 5'd1;
      end else begin
        col_d = col_q;
      end
      if (rise_s[B_DOWN] && !rise_s[B_UP]) begin
        row_d = (row_q == ROW_MAX) ? 5'd0 : row_q + 5'd1;
      end else if (rise_s[B_UP] && !rise_s[B_DOWN]) begin
        row_d = (row_q == 5'd0) ? ROW_MAX : row_q - 5'd1;
      end else begin
        row_d = row_q;
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
    if (pr_reset) begin
      pressed_d = 1'b0;
    end else if (!pressed_q && rise_s[B_SEL]) begin
      pressed_d = 1'b1;
    end else begin
      pressed_d = pressed_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q      <= '0;
      s2_q      <= '0;
      deb_q     <= '0;
      cnt_q     <= '0;
      col_q     <= 5'd0;
      row_q     <= 5'd0;
      pressed_q <= 1'b0;
    end else begin
      s1_q      <= raw_s;
      s2_q      <= s1_q;
      deb_q     <= deb_d;
      cnt_q     <= cnt_d;
      col_q     <= col_d;
      row_q     <= row_d;
      pressed_q <= pressed_d;
    end
  end

  assign pressed    = pressed_q;
  assign cursor_col = col_q;
  assign cursor_row = row_q;
  assign x_game     = 10'(X0 + CELL * int'(col_q));
  assign y_game     = 9'(Y0 + CELL * int'(row_q));

endmodule

// File: tb/tb_game_input_ctrl.sv
// Randomised and directed bench for game_input_ctrl against a behavioural model.
module tb_game_input_ctrl;

  localparam int DC   = 4;
  localparam int COLS = 16;
  localparam int ROWS = 12;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] btn = 5'd0;   // {sel,right,left,down,up}
  logic       pr_reset = 1'b0;
  logic       pressed;
  logic [9:0] x_game;
  logic [8:0] y_game;
  logic [4:0] cursor_col, cursor_row;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // behavioural model state
  bit [4:0] p1 = 5'd0, p2 = 5'd0, deb = 5'd0;
  int       run [5];
  int       m_col = 0, m_row = 0;
  bit       m_pressed = 1'b0;

  game_input_ctrl #(.DEBOUNCE_CYCLES(DC)) dut (
    .clock(clock), .reset(reset),
    .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]),
    .btn_right(btn[3]), .btn_sel(btn[4]),
    .pr_reset(pr_reset), .pressed(pressed),
    .x_game(x_game), .y_game(y_game),
    .cursor_col(cursor_col), .cursor_row(cursor_row)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a button level flips once raw (two edges late) has disagreed with it
  // for DC consecutive edges; cursor moves with modular arithmetic.
  task automatic model_step();
    bit [4:0] rise;
    int dx, dy;
    if (reset) begin
      p1 = 5'd0; p2 = 5'd0; deb = 5'd0;
      for (int i = 0; i < 5; i++) run[i] = 0;
      m_col = 0; m_row = 0; m_pressed = 1'b0;
    end else begin
      rise = 5'd0;
      for (int i = 0; i < 5; i++) begin
        if (p2[i] != deb[i]) begin
          run[i] = run[i] + 1;
          if (run[i] == DC) begin
            deb[i] = p2[i];
            run[i] = 0;
            rise[i] = p2[i];
          end
        end else begin
          run[i] = 0;
        end
      end
      p2 = p1;
      p1 = btn;
      if (!m_pressed) begin
        dx = int'(rise[3]) - int'(rise[2]);
        dy = int'(rise[1]) - int'(rise[0]);
        m_col = (m_col + dx + COLS) % COLS;
        m_row = (m_row + dy + ROWS) % ROWS;
      end
      if (pr_reset) m_pressed = 1'b0;
      else if (rise[4]) m_pressed = 1'b1;
    end
  endtask

  initial begin
    for (int i = 0; i < 5; i++) run[i] = 0;
    forever begin
      @(posedge clock);
      model_step();
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clock);
      if (chk_en) begin
        chk("cyc_pressed", int'(pressed), int'(m_pressed));
        chk("cyc_col", int'(cursor_col), m_col);
        chk("cyc_row", int'(cursor_row), m_row);
        chk("cyc_x", int'(x_game), 64 + 32 * m_col);
        chk("cyc_y", int'(y_game), 48 + 32 * m_row);
      end
    end
  end

  task automatic tap(input logic [4:0] mask);
    @(negedge clock);
    btn = mask;
    repeat (10) @(negedge clock);
    btn = 5'd0;
    repeat (10) @(negedge clock);
  endtask

  task automatic pin(input string name, input int col, input int row, input int prs);
    chk({name, "_col"}, int'(cursor_col), col);
    chk({name, "_row"}, int'(cursor_row), row);
    chk({name, "_pressed"}, int'(pressed), prs);
    chk({name, "_x"}, int'(x_game), 64 + 32 * col);
    chk({name, "_y"}, int'(y_game), 48 + 32 * row);
    chk({name, "_model_col"}, m_col, col);
    chk({name, "_model_row"}, m_row, row);
  endtask

  initial begin
    int hold;
    // 1. reset values
    reset = 1'b1;
    repeat (2) @(negedge clock);
    chk_en = 1'b1;
    chk("rst_pressed", int'(pressed), 0);
    chk("rst_x", int'(x_game), 64);
    chk("rst_y", int'(y_game), 48);
    chk("rst_col", int'(cursor_col), 0);
    chk("rst_row", int'(cursor_row), 0);
    reset = 1'b0;
    repeat (3) @(negedge clock);

    // 2. latency: first posedge after driving is edge 0, change after edge 5
    btn = 5'b01000;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clock);
      #1;
      chk("lat_col", int'(cursor_col), (k == 6) ? 1 : 0);
      chk("lat_x", int'(x_game), (k == 6) ? 96 : 64);
    end
    @(negedge clock);
    btn = 5'd0;
    repeat (10) @(negedge clock);
    btn = 5'b01000;
    repeat (3) @(negedge clock);
    btn = 5'd0;
    repeat (12) @(negedge clock);
    pin("glitch", 1, 0, 0);

    // 3. wrap-around
    tap(5'b00100);
    tap(5'b00100);
    pin("wrap_left", 15, 0, 0);
    chk("wrap_left_x544", int'(x_game), 544);
    tap(5'b00001);
    pin("wrap_up", 15, 11, 0);
    chk("wrap_up_y400", int'(y_game), 400);
    tap(5'b00010);
    pin("wrap_down", 15, 0, 0);

    // 4. simultaneous rises
    tap(5'b01100);
    pin("lr_cancel", 15, 0, 0);
    tap(5'b01010);
    pin("right_down", 0, 1, 0);

    // 5. press lock and clear
    tap(5'b01000); tap(5'b01000); tap(5'b01000); tap(5'b00010);
    tap(5'b10000);
    pin("sel_32", 3, 2, 1);
    chk("sel_x160", int'(x_game), 160);
    chk("sel_y112", int'(y_game), 112);
    tap(5'b01000);
    pin("locked", 3, 2, 1);
    @(negedge clock);
    pr_reset = 1'b1;
    @(negedge clock);
    pr_reset = 1'b0;
    chk("clear_pressed", int'(pressed), 0);
    tap(5'b01000);
    pin("rearm", 4, 2, 0);

    // 6a. pr_reset on the same edge as a sel rise
    @(negedge clock);
    btn = 5'b10000;
    repeat (5) @(negedge clock);
    pr_reset = 1'b1;
    @(negedge clock);
    pr_reset = 1'b0;
    repeat (8) @(negedge clock);
    chk("collide_pressed", int'(pressed), 0);
    btn = 5'd0;
    repeat (10) @(negedge clock);
    chk("collide_still0", int'(pressed), 0);
    tap(5'b10000);
    chk("collide_newsel", int'(pressed), 1);
    @(negedge clock);
    pr_reset = 1'b1;
    @(negedge clock);
    pr_reset = 1'b0;

    // 6b. reset mid-debounce while sel held
    btn = 5'b10000;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(posedge clock);
      #1;
      chk("rstmid_pressed", int'(pressed), (k == 6) ? 1 : 0);
    end
    @(negedge clock);
    btn = 5'd0;
    pr_reset = 1'b1;
    @(negedge clock);
    pr_reset = 1'b0;
    repeat (10) @(negedge clock);

    // randomised traffic including glitches, clears and resets
    for (int n = 0; n < 500; n++) begin
      btn = 5'($urandom) & 5'($urandom);
      pr_reset = ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 150) == 0);
      hold = $urandom_range(1, 10);
      @(negedge clock);
      pr_reset = 1'b0;
      reset = 1'b0;
      repeat (hold - 1) @(negedge clock);
    end
    btn = 5'd0;
    repeat (12) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule
